// File: rtl/berzerk_input_cond.sv
// Player-control conditioner for the berzerk core: synchronises and debounces
// the joystick/coin inputs, removes opposing directions and turns either coin
// source into a single fixed-width, rate-limited credit pulse.
module berzerk_input_cond #(
    parameter int unsigned TICK_DIV = 40000,
    parameter int unsigned DEB_N    = 4,
    parameter int unsigned COIN_ON  = 2000000,
    parameter int unsigned COIN_GAP = 2000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] joy_in,
    input  logic       coin_ext,
    output logic       right1,
    output logic       left1,
    output logic       down1,
    output logic       up1,
    output logic       fire1,
    output logic       start1,
    output logic       start2,
    output logic       coin1,
    output logic       coin_busy
);

    localparam int unsigned NB = 9;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 21;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Parameter range guards, evaluated at elaboration
    if (DEB_N < 1 || DEB_N > 15) begin : g_chk_deb
        $error("DEB_N must be in 1..15");
    end
    if (COIN_ON < 1 || COIN_ON > 32'(2 ** CW)) begin : g_chk_on
        $error("COIN_ON must be in 1..2^21");
    end
    if (COIN_GAP < 1 || COIN_GAP > 32'(2 ** CW)) begin : g_chk_gap
        $error("COIN_GAP must be in 1..2^21");
    end
    if (TICK_DIV < 1) begin : g_chk_tick
        $error("TICK_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_PULSE   = 2'd1,
        C_GAP     = 2'd2,
        C_RELEASE = 2'd3
    } coin_state_t;

    logic [NB-1:0] raw_c;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [PW-1:0] pre_q;
    logic          tick_c;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [NB-1:0] stable_q;
    logic          cs_c;
    coin_state_t   coin_state_q;
    logic [CW-1:0] coin_cnt_q;

    // Bit 8 carries the external coin button alongside the joystick byte
    assign raw_c  = {coin_ext, joy_in};
    assign tick_c = (pre_q == PW'(TICK_DIV - 1));
    assign cs_c   = stable_q[7] | stable_q[8];

    // Two-flop synchroniser for all raw inputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Debounce sample prescaler; tick is the cycle on which it wraps
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Per-bit debounce: accept a new level after DEB_N consecutive differing ticks
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
            stable_q <= '0;
        end else if (tick_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (deb_cnt_q[i] == DW'(DEB_N - 1)) begin
                        stable_q[i]  <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Registered player outputs; an opposing pair held together cancels out
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            right1 <= 1'b0;
            left1  <= 1'b0;
            down1  <= 1'b0;
            up1    <= 1'b0;
            fire1  <= 1'b0;
            start1 <= 1'b0;
            start2 <= 1'b0;
        end else begin
            right1 <= stable_q[0] & ~stable_q[1];
            left1  <= stable_q[1] & ~stable_q[0];
            down1  <= stable_q[2] & ~stable_q[3];
            up1    <= stable_q[3] & ~stable_q[2];
            fire1  <= stable_q[4];
            start1 <= stable_q[5];
            start2 <= stable_q[6];
        end
    end

    // Coin FSM: one fixed pulse per press, then a forced gap, then wait for release
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_state_q <= C_IDLE;
            coin_cnt_q   <= '0;
            coin1        <= 1'b0;
            coin_busy    <= 1'b0;
        end else begin
            case (coin_state_q)
                C_IDLE: begin
                    coin1 <= 1'b0;
                    if (cs_c) begin
                        coin_state_q <= C_PULSE;
                        coin_cnt_q   <= CW'(COIN_ON - 1);
                        coin_busy    <= 1'b1;
                    end
                end
                C_PULSE: begin
                    coin1 <= 1'b1;
                    if (coin_cnt_q == '0) begin
                        coin_state_q <= C_GAP;
                        coin_cnt_q   <= CW'(COIN_GAP - 1);
                    end else begin
                        coin_cnt_q <= coin_cnt_q - CW'(1);
                    end
                end
                C_GAP: begin
                    coin1 <= 1'b0;
                    if (coin_cnt_q == '0) begin
                        coin_state_q <= C_RELEASE;
                    end else begin
                        coin_cnt_q <= coin_cnt_q - CW'(1);
                    end
                end
                C_RELEASE: begin
                    coin1 <= 1'b0;
                    if (!cs_c) begin
                        coin_state_q <= C_IDLE;
                        coin_busy    <= 1'b0;
                    end
                end
                default: begin
                    coin_state_q <= C_IDLE;
                    coin1        <= 1'b0;
                    coin_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_berzerk_input_cond.sv
// Directed bench for berzerk_input_cond with shortened timing parameters.
module tb_berzerk_input_cond;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEB_N    = 3;
    localparam int unsigned COIN_ON  = 10;
    localparam int unsigned COIN_GAP = 6;
    localparam int          LAT_MAX  = (DEB_N + 1) * TICK_DIV + 3;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] joy_in;
    logic       coin_ext;
    logic       right1, left1, down1, up1, fire1, start1, start2, coin1, coin_busy;
    logic [6:0] outv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [7:0] joy;
        logic       cext;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clk_sys = ~clk_sys;

    assign outv = {start2, start1, fire1, up1, down1, left1, right1};

    berzerk_input_cond #(
        .TICK_DIV (TICK_DIV),
        .DEB_N    (DEB_N),
        .COIN_ON  (COIN_ON),
        .COIN_GAP (COIN_GAP)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy_in    (joy_in),
        .coin_ext  (coin_ext),
        .right1    (right1),
        .left1     (left1),
        .down1     (down1),
        .up1       (up1),
        .fire1     (fire1),
        .start1    (start1),
        .start2    (start2),
        .coin1     (coin1),
        .coin_busy (coin_busy)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Wait for the direction/button vector to settle, then check it stays put
    task automatic wait_dir(input logic [6:0] exp, input string nm);
        bit done;
        int viol;
        done = 1'b0;
        for (int i = 1; i <= LAT_MAX && !done; i++) begin
            step();
            if (outv == exp) done = 1'b1;
        end
        chk({nm, "_reach"}, 32'(outv), 32'(exp));
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (outv != exp) viol++;
        end
        chk({nm, "_hold"}, 32'(viol), 32'd0);
    endtask

    // Observe coin1 for n cycles: rising edges, high cycles, first rise cycle
    task automatic watch(input int n, output int rises, output int highs, output int t_rise);
        logic prev;
        prev   = coin1;
        rises  = 0;
        highs  = 0;
        t_rise = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (coin1) highs++;
            if (coin1 && !prev) begin
                rises++;
                if (t_rise < 0) t_rise = cyc;
            end
            prev = coin1;
        end
    endtask

    task automatic wait_busy_low(input string nm);
        for (int i = 0; i < LAT_MAX + 1 && coin_busy; i++) step();
        chk(nm, 32'(coin_busy), 32'd0);
    endtask

    initial begin
        int rises, highs, t1, t2, fall_c, fall_b, viol;
        logic pc, pb;

        // joy bits: [0]right [1]left [2]down [3]up [4]fire [5]start1 [6]start2 [7]coin
        vecs[0]  = '{joy: 8'h00, cext: 1'b0, exp: 7'h00};
        vecs[1]  = '{joy: 8'h10, cext: 1'b0, exp: 7'h10};
        vecs[2]  = '{joy: 8'h00, cext: 1'b0, exp: 7'h00};
        vecs[3]  = '{joy: 8'h0C, cext: 1'b0, exp: 7'h00};
        vecs[4]  = '{joy: 8'h08, cext: 1'b0, exp: 7'h08};
        vecs[5]  = '{joy: 8'h03, cext: 1'b0, exp: 7'h00};
        vecs[6]  = '{joy: 8'h02, cext: 1'b0, exp: 7'h02};
        vecs[7]  = '{joy: 8'h01, cext: 1'b0, exp: 7'h01};
        vecs[8]  = '{joy: 8'h60, cext: 1'b0, exp: 7'h60};
        vecs[9]  = '{joy: 8'h15, cext: 1'b0, exp: 7'h15};
        vecs[10] = '{joy: 8'h0F, cext: 1'b0, exp: 7'h00};
        vecs[11] = '{joy: 8'h00, cext: 1'b0, exp: 7'h00};

        reset    = 1'b1;
        joy_in   = 8'h00;
        coin_ext = 1'b0;
        repeat (3) step();
        chk("reset_state", 32'({outv, coin1, coin_busy}), 32'd0);
        reset = 1'b0;

        // Steady-state direction/button table
        for (int k = 0; k < 12; k++) begin
            joy_in   = vecs[k].joy;
            coin_ext = vecs[k].cext;
            wait_dir(vecs[k].exp, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d_coin", k), 32'({coin1, coin_busy}), 32'd0);
        end

        // Short fire glitch (two ticks) must be rejected
        viol   = 0;
        joy_in = 8'h10;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fire1) viol++;
        end
        joy_in = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fire1) viol++;
        end
        chk("glitch_fire", 32'(viol), 32'd0);
        joy_in = 8'h10;
        wait_dir(7'h10, "fire_press");
        joy_in = 8'h00;
        wait_dir(7'h00, "fire_release");

        // Held coin gives exactly one pulse
        joy_in = 8'h80;
        watch(100, rises, highs, t1);
        chk("hold_rises", 32'(rises), 32'd1);
        chk("hold_width", 32'(highs), 32'(COIN_ON));
        chk("hold_busy", 32'(coin_busy), 32'd1);
        joy_in = 8'h00;
        wait_busy_low("hold_busy_clear");

        // Short tap: busy drops COIN_GAP cycles after coin1 falls
        rises  = 0;
        highs  = 0;
        fall_c = -1;
        fall_b = -1;
        pc     = coin1;
        pb     = coin_busy;
        for (int i = 0; i < 80; i++) begin
            joy_in = (i < 12) ? 8'h80 : 8'h00;
            step();
            if (coin1) highs++;
            if (coin1 && !pc) rises++;
            if (!coin1 && pc) fall_c = cyc;
            if (!coin_busy && pb) fall_b = cyc;
            pc = coin1;
            pb = coin_busy;
        end
        chk("tap_rises", 32'(rises), 32'd1);
        chk("tap_width", 32'(highs), 32'(COIN_ON));
        chk("tap_gap", 32'(fall_b - fall_c), 32'(COIN_GAP));

        // Both sources together give one pulse; a later press gives another
        joy_in   = 8'h80;
        coin_ext = 1'b1;
        watch(60, rises, highs, t1);
        chk("dual_rises", 32'(rises), 32'd1);
        chk("dual_width", 32'(highs), 32'(COIN_ON));
        joy_in   = 8'h00;
        coin_ext = 1'b0;
        wait_busy_low("dual_busy_clear");
        repeat (10) step();
        coin_ext = 1'b1;
        watch(60, rises, highs, t2);
        chk("ext_rises", 32'(rises), 32'd1);
        chk("ext_width", 32'(highs), 32'(COIN_ON));
        chk("ext_spacing", 32'((t2 - t1) >= int'(COIN_ON + COIN_GAP)), 32'd1);
        coin_ext = 1'b0;
        wait_busy_low("ext_busy_clear");
        repeat (10) step();

        // Reset in the fifth PULSE cycle, coin and fire held throughout
        joy_in = 8'h90;
        for (int i = 0; i < 2 * LAT_MAX && !coin1; i++) step();
        chk("rst_pre_coin", 32'(coin1), 32'd1);
        chk("rst_pre_fire", 32'(fire1), 32'd1);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_outputs", 32'({outv, coin1, coin_busy}), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        t1 = cyc;
        watch(40, rises, highs, t2);
        chk("rst_rises", 32'(rises), 32'd1);
        chk("rst_width", 32'(highs), 32'(COIN_ON));
        chk("rst_redebounce", 32'((t2 - t1) > 8 && (t2 - t1) <= LAT_MAX + 1), 32'd1);
        chk("rst_fire_back", 32'(fire1), 32'd1);
        joy_in = 8'h00;
        wait_busy_low("rst_busy_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
